// File: rtl/incr_chk_pkg.sv
// rtl/incr_chk_pkg.sv - shared types, widths, LFSR step and corner vectors for incr_stim_checker
package incr_chk_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} chk_state_t;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  localparam int SMALL_W = 2;
  localparam int QUAD_W  = 40;
  localparam int WIDE_W  = 70;

  localparam logic [SMALL_W-1:0] CORNER0_SMALL = '0;
  localparam logic [QUAD_W-1:0]  CORNER0_QUAD  = '0;
  localparam logic [WIDE_W-1:0]  CORNER0_WIDE  = '0;
  localparam logic [SMALL_W-1:0] CORNER1_SMALL = '1;
  localparam logic [QUAD_W-1:0]  CORNER1_QUAD  = '1;
  localparam logic [WIDE_W-1:0]  CORNER1_WIDE  = '1;
  // Carry out of the low 64 bits of the wide field (and the low 32 of the quad field)
  localparam logic [SMALL_W-1:0] CORNER2_SMALL = 2'b10;
  localparam logic [QUAD_W-1:0]  CORNER2_QUAD  = 40'h00_FFFF_FFFF;
  localparam logic [WIDE_W-1:0]  CORNER2_WIDE  = 70'h0_FFFF_FFFF_FFFF_FFFF;

  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return {1'b0, l[31:1]} ^ (l[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/incr_stim_checker_if.sv
// rtl/incr_stim_checker_if.sv - stimulus/response bus between the checker and the increment datapath
interface incr_stim_checker_if;
  import incr_chk_pkg::*;

  logic [SMALL_W-1:0] in_small;
  logic [QUAD_W-1:0]  in_quad;
  logic [WIDE_W-1:0]  in_wide;
  logic [SMALL_W-1:0] out_small;
  logic [QUAD_W-1:0]  out_quad;
  logic [WIDE_W-1:0]  out_wide;

  modport master (output in_small, in_quad, in_wide, input out_small, out_quad, out_wide);
  modport slave  (input in_small, in_quad, in_wide, output out_small, out_quad, out_wide);
endinterface

// File: rtl/incr_chk_lfsr.sv
// rtl/incr_chk_lfsr.sv - 32-bit Galois LFSR with seed load and advance enable
module incr_chk_lfsr
  import incr_chk_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2468
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        load,
  input  logic        adv,
  output logic [31:0] lfsr_q
);
  // An all-zero state would lock up the LFSR
  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l)  lfsr_q <= SEED_EFF;
    else if (load) lfsr_q <= SEED_EFF;
    else if (adv)  lfsr_q <= lfsr_next(lfsr_q);
  end
endmodule

// File: rtl/incr_stim_checker.sv
// rtl/incr_stim_checker.sv - LFSR stimulus source and self-checker for the increment datapath
// Optional build macro INCR_CHK_CORNER_EN replaces vectors 0..2 with fixed corner values.
module incr_stim_checker
  import incr_chk_pkg::*;
#(
  parameter int unsigned NUM_VECTORS = 256,
  parameter logic [31:0] SEED        = 32'hACE1_2468
) (
  input  logic                       clk,
  input  logic                       reset_l,
  input  logic                       start,
  input  logic                       abort,
  incr_stim_checker_if.master        bus,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [15:0]                err_count,
  output logic [15:0]                first_err
);
  localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);

  chk_state_t          state;
  logic [15:0]         vec_idx, cap_idx;
  logic [31:0]         lfsr_q;
  logic                cap_valid;
  logic [SMALL_W-1:0]  exp_small, cap_small, inc_small, nxt_small;
  logic [QUAD_W-1:0]   exp_quad, cap_quad, inc_quad, nxt_quad;
  logic [WIDE_W-1:0]   exp_wide, cap_wide, inc_wide, nxt_wide;
  logic                begin_run, more, load_vec, lfsr_adv, mismatch;
  logic [15:0]         err_nxt, first_nxt;
`ifdef INCR_CHK_CORNER_EN
  logic [15:0]         load_idx;
`endif

  incr_chk_lfsr #(.SEED(SEED)) u_lfsr (
    .clk    (clk),
    .reset_l(reset_l),
    .load   (abort),
    .adv    (lfsr_adv),
    .lfsr_q (lfsr_q)
  );

  always_comb begin
    begin_run = start && !abort && (state == IDLE || state == DONE);
    more      = (state == RUN) && (vec_idx != LAST_IDX);
    load_vec  = begin_run || more;
    nxt_small = lfsr_q[1:0];
    nxt_quad  = {lfsr_q[7:0], lfsr_q};
    nxt_wide  = {lfsr_q[5:0], lfsr_q, lfsr_q};
`ifdef INCR_CHK_CORNER_EN
    load_idx  = begin_run ? 16'd0 : vec_idx + 16'd1;
    lfsr_adv  = load_vec && !abort && (load_idx > 16'd2);
    case (load_idx)
      16'd0:   begin nxt_small = CORNER0_SMALL; nxt_quad = CORNER0_QUAD; nxt_wide = CORNER0_WIDE; end
      16'd1:   begin nxt_small = CORNER1_SMALL; nxt_quad = CORNER1_QUAD; nxt_wide = CORNER1_WIDE; end
      16'd2:   begin nxt_small = CORNER2_SMALL; nxt_quad = CORNER2_QUAD; nxt_wide = CORNER2_WIDE; end
      default: ;
    endcase
`else
    lfsr_adv  = load_vec && !abort;
`endif
    // Increments truncate to the native width so that wrap compares as legal
    inc_small = exp_small + 1'b1;
    inc_quad  = exp_quad + 1'b1;
    inc_wide  = exp_wide + 1'b1;
    mismatch  = cap_valid && ((cap_small != inc_small) || (cap_quad != inc_quad) ||
                              (cap_wide != inc_wide));
    err_nxt   = (mismatch && err_count != 16'hFFFF) ? err_count + 16'd1 : err_count;
    first_nxt = (mismatch && first_err == 16'hFFFF) ? cap_idx : first_err;
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state <= IDLE; vec_idx <= '0; cap_idx <= '0; cap_valid <= 1'b0;
      bus.in_small <= '0; bus.in_quad <= '0; bus.in_wide <= '0;
      exp_small <= '0; exp_quad <= '0; exp_wide <= '0;
      cap_small <= '0; cap_quad <= '0; cap_wide <= '0;
      busy <= 1'b0; done <= 1'b0; pass <= 1'b0; err_count <= '0; first_err <= 16'hFFFF;
    end else if (abort) begin
      state <= IDLE; vec_idx <= '0; cap_idx <= '0; cap_valid <= 1'b0;
      bus.in_small <= '0; bus.in_quad <= '0; bus.in_wide <= '0;
      exp_small <= '0; exp_quad <= '0; exp_wide <= '0;
      cap_small <= '0; cap_quad <= '0; cap_wide <= '0;
      busy <= 1'b0; done <= 1'b0; pass <= 1'b0; err_count <= '0; first_err <= 16'hFFFF;
    end else begin
      cap_valid <= (state == RUN);
      if (state == RUN) begin
        cap_idx   <= vec_idx;
        exp_small <= bus.in_small;  exp_quad <= bus.in_quad;  exp_wide <= bus.in_wide;
        cap_small <= bus.out_small; cap_quad <= bus.out_quad; cap_wide <= bus.out_wide;
      end
      if (cap_valid) begin
        err_count <= err_nxt;
        first_err <= first_nxt;
      end
      if (load_vec) begin
        bus.in_small <= nxt_small; bus.in_quad <= nxt_quad; bus.in_wide <= nxt_wide;
      end
      case (state)
        IDLE, DONE: if (begin_run) begin
          state <= RUN; busy <= 1'b1; done <= 1'b0; pass <= 1'b0;
          vec_idx <= '0; err_count <= '0; first_err <= 16'hFFFF;
        end
        RUN: if (more) vec_idx <= vec_idx + 16'd1;
             else      state <= DRAIN;
        DRAIN: begin
          state <= DONE; busy <= 1'b0; done <= 1'b1;
          pass  <= (err_nxt == 16'd0);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
